latch_write_sequencer: RTL and testbench
========================================

// Module: latch_write_sequencer
// PURPOSE
//  Upstream driver for lvl_sensitve_d_latch. Accepts data words over a valid/ready handshake and
//  generates a glitch-free, registered En window with guaranteed D setup before and hold after it.
//  Its D/En outputs connect directly to the latch's D/En pins.
// PARAMETERS
//  WIDTH         1  data width; one latch per bit
//  SETUP_CYCLES  1  cycles D is stable with En=0 before the window opens (>=1)
//  OPEN_CYCLES   2  cycles En is held high (>=1)
//  HOLD_CYCLES   1  cycles D is held with En=0 after the window closes (>=1)
// PORTS
//  clk       in   1      single clock, all state on posedge
//  rst       in   1      asynchronous, active-high reset
//  in_valid  in   1      write request
//  in_ready  out  1      sequencer can accept a word
//  in_data   in   WIDTH  word to write into the latch
//  d_out     out  WIDTH  drives latch D
//  en_out    out  1      drives latch En; registered, glitch-free
//  busy      out  1      write sequence in progress (state != IDLE)
//  done      out  1      one-cycle pulse when a sequence completes
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; d_out=0, en_out=0, done=0, busy=0, in_ready=1 once released.
//  FSM: IDLE -> SETUP -> OPEN -> HOLD -> IDLE. One phase down-counter is loaded with N-1 on phase entry.
//  It decrements each cycle, and the phase exits on the edge where the count is 0.
//  IDLE: in_ready=1. On an edge with in_valid&&in_ready: d_out<=in_data, enter SETUP.
//  SETUP: en_out=0; d_out held. Lasts SETUP_CYCLES.
//  OPEN: en_out=1 for exactly OPEN_CYCLES cycles; d_out held.
//  HOLD: en_out=0; d_out held. Lasts HOLD_CYCLES.
//  On exit to IDLE, done=1 for the first IDLE cycle. d_out keeps its last value until the next accept.
//  en_out, d_out and done are flops; there is no combinational path from inputs to outputs.
//  d_out never changes while en_out=1, nor in the cycle en_out falls.
//  in_ready=0 in SETUP/OPEN/HOLD. in_valid is ignored there; requests are not queued.
//  Throughput: one word per SETUP+OPEN+HOLD+1 cycles (5 at defaults).
//  A request present in the done cycle is accepted in that cycle (back-to-back allowed).
//  Reset mid-sequence: en_out drops asynchronously and the word is abandoned; no done is produced.
//  Counter width = $clog2(max(SETUP,OPEN,HOLD)+1). A parameter <1 is an elaboration error ($fatal).
// CONFIGURATION
//  LATCH_WR_READBACK_EN defined: adds ports f_in (in, WIDTH; the latch output) and mismatch (out, 1).
//   On the HOLD->IDLE edge, mismatch<=(f_in!=d_out) and stays valid until the next accept.
//   mismatch resets to 0 and is cleared on accept.
//  LATCH_WR_READBACK_EN undefined: neither port exists and there is no compare logic.
// STRUCTURE
//  Package latch_wr_pkg: typedef enum logic [1:0] {IDLE,SETUP,OPEN,HOLD} lws_state_t;
//   function cnt_width(s,o,h) returning the counter width.
//  Sub-module lws_phase_counter: loadable down-counter with a zero flag; clk/rst, load, load_val, zero.
// TESTING
//  Defaults, in_data=1 accepted at edge 0 -> SETUP cycle 1 (en=0,d=1); en=1 in cycles 2-3;
//   HOLD cycle 4 (en=0,d=1); done=1 in cycle 5.
//  in_valid held high with data 1,0,1 -> three back-to-back writes at 5-cycle spacing.
//   Latch model f tracks 1,0,1; in_ready=0 inside each sequence.
//  in_valid pulsed during OPEN -> ignored: no extra en window, d_out unchanged.
//  rst asserted mid-OPEN -> en_out=0 within the same cycle (async); no done; next accept works normally.
//  SETUP=3,OPEN=1,HOLD=2,WIDTH=8, data 8'hA5 -> en high exactly 1 cycle, 3 cycles after d_out=A5.
//   d_out stable for 2 cycles after en falls.
//  READBACK_EN: latch model stuck at 0, write 1 -> mismatch=1 in the done cycle.
//   With a correct latch, mismatch=0.

Source files
------------

// File: rtl/latch_wr_pkg.sv
// rtl/latch_wr_pkg.sv - shared state encoding and counter sizing for the latch write sequencer
package latch_wr_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} lws_state_t;

    // Wide enough to hold the largest phase length minus one
    function automatic int cnt_width(input int s, input int o, input int h);
        int m;
        m = s;
        if (o > m) m = o;
        if (h > m) m = h;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lws_phase_counter.sv
// rtl/lws_phase_counter.sv - loadable phase down-counter with zero flag
module lws_phase_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] count;

    // Saturates at zero so an idle sequencer never wraps the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - CW'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// rtl/latch_write_sequencer.sv - registered D/En sequencer for a level-sensitive latch
// Optional readback compare is enabled with LATCH_WR_READBACK_EN.
module latch_write_sequencer
    import latch_wr_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int SETUP_CYCLES = 1,
    parameter int OPEN_CYCLES  = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] d_out,
    output logic             en_out,
    output logic             busy,
    output logic             done
`ifdef LATCH_WR_READBACK_EN
    ,
    input  logic [WIDTH-1:0] f_in,
    output logic             mismatch
`endif
);

    localparam int CW = cnt_width(SETUP_CYCLES, OPEN_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

    generate
        if (WIDTH < 1 || SETUP_CYCLES < 1 || OPEN_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
            $fatal(1, "latch_write_sequencer: WIDTH and all phase lengths must be >= 1");
        end
    endgenerate

    lws_state_t    state, next_state;
    logic          accept;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_zero;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    lws_phase_counter #(.CW(CW)) u_phase_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state)
            IDLE: if (accept) begin
                next_state   = SETUP;
                cnt_load     = 1'b1;
                cnt_load_val = SETUP_LD;
            end
            SETUP: if (cnt_zero) begin
                next_state   = OPEN;
                cnt_load     = 1'b1;
                cnt_load_val = OPEN_LD;
            end
            OPEN: if (cnt_zero) begin
                next_state   = HOLD;
                cnt_load     = 1'b1;
                cnt_load_val = HOLD_LD;
            end
            HOLD: if (cnt_zero) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // En is decoded from next_state so it is a clean flop output aligned with the OPEN phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out  <= '0;
            en_out <= 1'b0;
            done   <= 1'b0;
        end else begin
            en_out <= (next_state == OPEN);
            done   <= (state == HOLD) && (next_state == IDLE);
            if (accept)
                d_out <= in_data;
        end
    end

`ifdef LATCH_WR_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mismatch <= 1'b0;
        else if (accept)
            mismatch <= 1'b0;
        else if ((state == HOLD) && (next_state == IDLE))
            mismatch <= (f_in != d_out);
    end
`else
    // No readback path in this build
`endif

endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb/tb_latch_write_sequencer.sv - self-checking bench for latch_write_sequencer
module tb_latch_write_sequencer;

    logic       clk, rst;
    logic       in_valid, in_ready, in_data, d_out, en_out, busy, done;
    logic       v8, rdy8, en8, busy8, done8;
    logic [7:0] data8, d8;
    logic       f_lat;
`ifdef LATCH_WR_READBACK_EN
    logic       stuck, f_in, mismatch, mm8;
    logic [7:0] f8;
    assign f_in = stuck ? 1'b0 : f_lat;
    assign f8   = d8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    latch_write_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .d_out(d_out), .en_out(en_out), .busy(busy), .done(done)
`ifdef LATCH_WR_READBACK_EN
        , .f_in(f_in), .mismatch(mismatch)
`endif
    );

    latch_write_sequencer #(.WIDTH(8), .SETUP_CYCLES(3), .OPEN_CYCLES(1), .HOLD_CYCLES(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(data8),
        .d_out(d8), .en_out(en8), .busy(busy8), .done(done8)
`ifdef LATCH_WR_READBACK_EN
        , .f_in(f8), .mismatch(mm8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural latch on the default instance's D/En
    always @(en_out, d_out) if (en_out) f_lat = d_out;

    typedef struct {
        bit v; bit din; bit en; bit dq; bit done; bit rdy; bit f;
    } vec_t;
    vec_t tbl[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    localparam int S = 1, O = 2, H = 1, L = S + O + H;
    int pos, ens, dones, bad, first_en, first_d, done_j;
    logic md, rv, rd, rdy_m;
    logic [7:0] d_hist[1:10];

    initial begin
        tbl[0]  = '{1,1, 0,1,0,0,0};
        tbl[1]  = '{1,0, 1,1,0,0,1};
        tbl[2]  = '{1,0, 1,1,0,0,1};
        tbl[3]  = '{1,0, 0,1,0,0,1};
        tbl[4]  = '{1,0, 0,1,1,1,1};
        tbl[5]  = '{1,0, 0,0,0,0,1};
        tbl[6]  = '{1,1, 1,0,0,0,0};
        tbl[7]  = '{1,1, 1,0,0,0,0};
        tbl[8]  = '{1,1, 0,0,0,0,0};
        tbl[9]  = '{1,1, 0,0,1,1,0};
        tbl[10] = '{1,1, 0,1,0,0,0};
        tbl[11] = '{1,0, 1,1,0,0,1};
        tbl[12] = '{1,0, 1,1,0,0,1};
        tbl[13] = '{1,0, 0,1,0,0,1};
        tbl[14] = '{0,0, 0,1,1,1,1};
        tbl[15] = '{0,0, 0,1,0,1,1};

        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; v8 = 1'b0; data8 = 8'h00; f_lat = 1'b0;
`ifdef LATCH_WR_READBACK_EN
        stuck = 1'b0;
`endif
        repeat (2) tick();
        chk("reset_en", en_out, 0);
        chk("reset_d", d_out, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("reset_ready", in_ready, 1);

        // Single write then back-to-back writes of 1,0,1 with in_valid held high
        for (int i = 0; i < 16; i++) begin
            in_valid = tbl[i].v;
            in_data  = tbl[i].din;
            tick();
            chk($sformatf("tbl%0d_en", i), en_out, tbl[i].en);
            chk($sformatf("tbl%0d_d", i), d_out, tbl[i].dq);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
            chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_busy", i), busy, !tbl[i].rdy);
            chk($sformatf("tbl%0d_latch", i), f_lat, tbl[i].f);
        end

        // Request pulsed during OPEN is ignored
        in_valid = 1'b1; in_data = 1'b0; ens = 0; dones = 0; bad = 0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            in_valid = (j == 2);
            in_data  = 1'b1;
            ens   += int'(en_out);
            dones += int'(done);
            if (d_out !== 1'b0) bad++;
        end
        chk("pulse_open_en_cycles", ens, 2);
        chk("pulse_open_dones", dones, 1);
        chk("pulse_open_d_changes", bad, 0);

        // Reset mid-OPEN drops En immediately and abandons the word
        in_valid = 1'b1; in_data = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst_mid_en_before", en_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_en_async", en_out, 0);
        chk("rst_mid_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        dones = 0; ens = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            dones += int'(done);
            ens   += int'(en_out);
        end
        chk("rst_mid_no_done", dones, 0);
        chk("rst_mid_no_en", ens, 0);
        in_valid = 1'b1; in_data = 1'b1; ens = 0; dones = 0; bad = 0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            in_valid = 1'b0;
            ens   += int'(en_out);
            dones += int'(done);
            if (d_out !== 1'b1) bad++;
        end
        chk("post_rst_en_cycles", ens, 2);
        chk("post_rst_dones", dones, 1);
        chk("post_rst_d", bad, 0);

        // Wide instance with asymmetric phases
        v8 = 1'b1; data8 = 8'hA5; ens = 0; first_en = -1; first_d = -1; done_j = -1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            v8 = 1'b0;
            d_hist[j] = d8;
            if (en8 === 1'b1) begin
                ens++;
                if (first_en < 0) first_en = j;
            end
            if (d8 === 8'hA5 && first_d < 0) first_d = j;
            if (done8 === 1'b1 && done_j < 0) done_j = j;
        end
        chk("w8_first_d", first_d, 1);
        chk("w8_first_en", first_en, 4);
        chk("w8_en_cycles", ens, 1);
        chk("w8_hold_d1", d_hist[5], 8'hA5);
        chk("w8_hold_d2", d_hist[6], 8'hA5);
        chk("w8_done_cycle", done_j, 7);
`ifdef LATCH_WR_READBACK_EN
        chk("w8_mismatch", mm8, 0);

        stuck = 1'b1; in_valid = 1'b1; in_data = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("rb_stuck_done", done, 1);
        chk("rb_stuck_mismatch", mismatch, 1);
        stuck = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rb_clear_on_accept", mismatch, 0);
        repeat (4) tick();
        chk("rb_good_done", done, 1);
        chk("rb_good_mismatch", mismatch, 0);
`endif

        // Randomised traffic against a cycle-position reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pos = 0; md = 1'b0;
        for (int k = 0; k < 300; k++) begin
            rv = (($urandom % 3) != 0);
            rd = $urandom_range(0, 1);
            in_valid = rv;
            in_data  = rd;
            rdy_m = (pos == 0) || (pos == L + 1);
            if (rdy_m && rv) begin
                pos = 1;
                md  = rd;
            end else if (pos >= 1 && pos <= L) begin
                pos++;
            end else begin
                pos = 0;
            end
            tick();
            chk("rnd_en", en_out, (pos >= S + 1 && pos <= S + O));
            chk("rnd_d", d_out, md);
            chk("rnd_done", done, (pos == L + 1));
            chk("rnd_busy", busy, (pos >= 1 && pos <= L));
            chk("rnd_ready", in_ready, !(pos >= 1 && pos <= L));
        end
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
